rf_wb_scheduler: RTL and testbench
==================================

// Module: rf_wb_scheduler
// PURPOSE
//  Controls the shared write port of the RegisterFile and tracks in-flight
//  destination registers. Sits between issue, the two writeback producers
//  (EXU: ALU results; LSU: load data) and the RegisterFile write port.
//  - Keeps a busy scoreboard of registers that have a write in flight.
//  - Stalls issue on RAW/WAW hazards.
//  - Round-robin arbitrates the producers onto the one write port.
// PARAMETERS
//  ADDR_WIDTH  5   register index width; 2**ADDR_WIDTH registers, x0 hardwired
//  DATA_WIDTH  32  register data width
// PORTS
//  clk         in   1           clock; all state updates on posedge
//  rst         in   1           reset, asynchronous, active-high
//  iss_valid   in   1           issue stage presents an instruction
//  iss_rs1     in   ADDR_WIDTH  source register 1
//  iss_rs2     in   ADDR_WIDTH  source register 2
//  iss_rd      in   ADDR_WIDTH  destination register (0 = no writeback)
//  iss_ready   out  1           instruction may issue this cycle
//  exu_valid   in   1           EXU writeback request
//  exu_rd      in   ADDR_WIDTH  EXU destination
//  exu_data    in   DATA_WIDTH  EXU result
//  exu_ready   out  1           EXU request granted this cycle
//  lsu_valid   in   1           LSU writeback request
//  lsu_rd      in   ADDR_WIDTH  LSU destination
//  lsu_data    in   DATA_WIDTH  LSU load data
//  lsu_ready   out  1           LSU request granted this cycle
//  rf_wen      out  1           to RegisterFile Regwr
//  rf_waddr    out  ADDR_WIDTH  to RegisterFile Rw
//  rf_wdata    out  DATA_WIDTH  to RegisterFile busW
//  busy_vec    out  2**ADDR_WIDTH  scoreboard; bit i = write to x[i] in flight
//  pend_cnt    out  ADDR_WIDTH+1   number of set busy bits
//  err_spur    out  1           sticky: writeback granted to a non-busy rd!=0
// BEHAVIOUR
//  Reset (async, immediate): busy_vec=0, pend_cnt=0, rf_wen=0, rf_waddr=0,
//   rf_wdata=0, err_spur=0, RR pointer=EXU-first. Reset mid-transfer drops
//   any granted but unwritten result; no write reaches the RegisterFile.
//  Hazard check (combinational, uses registered busy_vec only):
//   iss_ready = !(busy[rs1]&&rs1!=0) && !(busy[rs2]&&rs2!=0)
//               && !(busy[rd]&&rd!=0).
//   iss_ready does not depend on iss_valid.
//  Issue: iss_valid&&iss_ready&&iss_rd!=0 -> busy[iss_rd] set at next edge.
//  Arbitration (combinational grant, same cycle as valid):
//   - one requester valid -> it is granted.
//   - both valid -> grant the side not granted last; update pointer only
//     when both contend.
//   - valid&&!ready holds rd/data stable until granted (producer rule).
//   - exu_ready/lsu_ready are 0 when the side is not valid.
//  Write port: registered, 1-cycle latency.
//   - Grant in cycle N -> rf_wen=(rd!=0), rf_waddr=rd, rf_wdata=data in N+1.
//   - rf_wen=0 in any cycle after no grant.
//   - busy[rd] clears on the N+1 edge, the same edge the RegisterFile
//     writes, so an issue in N+2 reads the new value with no bypass.
//  Simultaneous set/clear of the same index: impossible for a legal
//   sequence (WAW stall). If it occurs, set wins; err_spur is unaffected.
//  rd=0 writeback: granted normally, rf_wen stays 0, busy untouched.
//  Spurious writeback (grant with rd!=0 and busy[rd]=0 at grant):
//   write still performed, err_spur set and held until rst.
//  pend_cnt: registered; tracks busy_vec popcount exactly. Max 2**ADDR_WIDTH-1.
// TESTING
//  1 reset mid-op: grant in N, assert rst in N+1 -> rf_wen=0, busy_vec=0,
//    err_spur=0 immediately; no RegisterFile write occurs.
//  2 issue rd=5 -> busy[5]=1, pend_cnt=1; issue rs1=5 stalls (iss_ready=0);
//    exu wb rd=5 data=0xA5 -> rf_wen=1, waddr=5, wdata=0xA5 next cycle;
//    busy[5]=0 after that edge; stalled issue proceeds the cycle after.
//  3 busy x3 (LSU), x4 (EXU); both valid 4 cycles, never consumed ->
//    grants alternate EXU,LSU,EXU,LSU from reset; each grant writes once.
//  4 issue rd=0 and wb rd=0 data=0xFFFF_FFFF -> rf_wen=0, busy_vec and
//    pend_cnt unchanged; rs1=0 never stalls.
//  5 wb rd=7 with busy[7]=0 -> write performed, err_spur=1 and stays 1
//    after further legal traffic.
//  6 fill x1..x31 busy via 31 issues -> pend_cnt=31; drain all via
//    alternating EXU/LSU -> pend_cnt=0, every index written exactly once.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler
// Owns the single RegisterFile write port and the in-flight destination
// scoreboard. It stalls issue on RAW/WAW hazards against the scoreboard. It
// round-robins the EXU and LSU writeback requests onto the port, and it
// registers the winning result so that it is written one cycle after the grant.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   iss_valid/rs1/rs2/rd  instruction offered by issue
//   iss_ready             no hazard on rs1/rs2/rd (independent of iss_valid)
//   exu_valid/rd/data     EXU writeback request; exu_ready = granted now
//   lsu_valid/rd/data     LSU writeback request; lsu_ready = granted now
//   rf_wen/waddr/wdata    RegisterFile write port (registered)
//   busy_vec              scoreboard, bit i = write to x[i] in flight
//   pend_cnt              popcount of busy_vec
//   err_spur              sticky: grant to a non-busy nonzero rd
module rf_wb_scheduler #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_valid,
    input  logic [ADDR_WIDTH-1:0]    iss_rs1,
    input  logic [ADDR_WIDTH-1:0]    iss_rs2,
    input  logic [ADDR_WIDTH-1:0]    iss_rd,
    output logic                     iss_ready,
    input  logic                     exu_valid,
    input  logic [ADDR_WIDTH-1:0]    exu_rd,
    input  logic [DATA_WIDTH-1:0]    exu_data,
    output logic                     exu_ready,
    input  logic                     lsu_valid,
    input  logic [ADDR_WIDTH-1:0]    lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    output logic                     lsu_ready,
    output logic                     rf_wen,
    output logic [ADDR_WIDTH-1:0]    rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    output logic [(2**ADDR_WIDTH)-1:0] busy_vec,
    output logic [ADDR_WIDTH:0]      pend_cnt,
    output logic                     err_spur
);

    localparam int unsigned NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    logic [NUM_REGS-1:0]   busyQ;
    logic [NUM_REGS-1:0]   busyNext;
    logic [NUM_REGS-1:0]   setMask;
    logic [NUM_REGS-1:0]   clrMask;
    logic                  preferLsuQ;   // 1: LSU wins the next contention
    logic                  grantExu;
    logic                  grantLsu;
    logic                  grantAny;
    logic                  bothValid;
    logic [ADDR_WIDTH-1:0] grantRd;
    logic [DATA_WIDTH-1:0] grantData;
    logic                  spurious;

    // Hazard check against the registered scoreboard only.
    always_comb begin
        iss_ready = 1'b1;
        if (busyQ[iss_rs1] && (iss_rs1 != '0)) iss_ready = 1'b0;
        if (busyQ[iss_rs2] && (iss_rs2 != '0)) iss_ready = 1'b0;
        if (busyQ[iss_rd]  && (iss_rd  != '0)) iss_ready = 1'b0;
    end

    // Round-robin grant. The pointer only matters when both sides request.
    always_comb begin
        bothValid = exu_valid && lsu_valid;
        grantExu  = exu_valid && (!lsu_valid || !preferLsuQ);
        grantLsu  = lsu_valid && (!exu_valid ||  preferLsuQ);
        grantAny  = grantExu || grantLsu;
        grantRd   = grantLsu ? lsu_rd   : exu_rd;
        grantData = grantLsu ? lsu_data : exu_data;
        spurious  = grantAny && (grantRd != '0) && !busyQ[grantRd];
    end

    assign exu_ready = grantExu;
    assign lsu_ready = grantLsu;

    // Scoreboard next state. The clear comes from the write being committed
    // this edge, and a same-index set takes priority over that clear.
    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (iss_valid && iss_ready && (iss_rd != '0)) setMask[iss_rd] = 1'b1;
        if (rf_wen) clrMask[rf_waddr] = 1'b1;
        busyNext = (busyQ & ~clrMask) | setMask;
    end

    // State and write-port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busyQ      <= '0;
            pend_cnt   <= '0;
            preferLsuQ <= 1'b0;
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            err_spur   <= 1'b0;
        end else begin
            busyQ    <= busyNext;
            pend_cnt <= CNT_WIDTH'($countones(busyNext));
            if (bothValid) preferLsuQ <= !preferLsuQ;
            rf_wen <= grantAny && (grantRd != '0);
            if (grantAny) begin
                rf_waddr <= grantRd;
                rf_wdata <= grantData;
            end
            if (spurious) err_spur <= 1'b1;
        end
    end

    assign busy_vec = busyQ;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler
// Directed bench for rf_wb_scheduler. A scoreboard-level model tracks the
// in-flight registers, the round-robin turn, the pending write and the sticky
// error. The DUT is compared against that model on every negedge. Directed
// literal checks pin both the model and the DUT.
module tb_rf_wb_scheduler;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          iss_valid = 1'b0;
    logic [AW-1:0] iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
    logic          iss_ready;
    logic          exu_valid = 1'b0;
    logic [AW-1:0] exu_rd = '0;
    logic [DW-1:0] exu_data = '0;
    logic          exu_ready;
    logic          lsu_valid = 1'b0;
    logic [AW-1:0] lsu_rd = '0;
    logic [DW-1:0] lsu_data = '0;
    logic          lsu_ready;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [NR-1:0] busy_vec;
    logic [AW:0]   pend_cnt;
    logic          err_spur;

    int errors = 0;
    int checks = 0;
    int wrCnt[NR];
    int snap[NR];

    rf_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rd(iss_rd), .iss_ready(iss_ready),
        .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data),
        .exu_ready(exu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .lsu_ready(lsu_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_vec(busy_vec), .pend_cnt(pend_cnt), .err_spur(err_spur)
    );

    always #5 clk = ~clk;

    // Model state: which registers await a write, whose turn it is when
    // both producers contend, the write committed next edge, sticky error.
    bit          mBusy[NR];
    bit          mPreferLsu;
    bit          mPendWen;
    int          mPendAddr;
    int          mPendData;
    bit          mErr;

    function automatic bit hazard(input int r);
        return (r != 0) && mBusy[r];
    endfunction

    function automatic bit expIssReady();
        return !(hazard(int'(iss_rs1)) || hazard(int'(iss_rs2)) || hazard(int'(iss_rd)));
    endfunction

    // Returns 0 = nobody, 1 = EXU, 2 = LSU.
    function automatic int expWinner();
        if (exu_valid && lsu_valid) return mPreferLsu ? 2 : 1;
        if (exu_valid) return 1;
        if (lsu_valid) return 2;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NR); i++) mBusy[i] = 1'b0;
            mPreferLsu = 1'b0;
            mPendWen   = 1'b0;
            mPendAddr  = 0;
            mPendData  = 0;
            mErr       = 1'b0;
        end else begin
            int  w;
            int  wRd;
            int  wData;
            bit  canIssue;
            w        = expWinner();
            canIssue = expIssReady();
            wRd      = (w == 2) ? int'(lsu_rd) : int'(exu_rd);
            wData    = (w == 2) ? int'(lsu_data) : int'(exu_data);
            if (w != 0 && wRd != 0 && !mBusy[wRd]) mErr = 1'b1;
            if (mPendWen) mBusy[mPendAddr] = 1'b0;
            if (iss_valid && canIssue && iss_rd != 0) mBusy[int'(iss_rd)] = 1'b1;
            mPendWen = (w != 0) && (wRd != 0);
            if (w != 0) begin
                mPendAddr = wRd;
                mPendData = wData;
            end
            if (exu_valid && lsu_valid) mPreferLsu = !mPreferLsu;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmpModel();
        logic [NR-1:0] vec;
        int            cnt;
        int            w;
        cnt = 0;
        for (int i = 0; i < int'(NR); i++) begin
            vec[i] = mBusy[i];
            cnt += int'(mBusy[i]);
        end
        w = expWinner();
        check("m_iss_ready", 64'(iss_ready), 64'(expIssReady()));
        check("m_exu_ready", 64'(exu_ready), 64'(w == 1));
        check("m_lsu_ready", 64'(lsu_ready), 64'(w == 2));
        check("m_rf_wen", 64'(rf_wen), 64'(mPendWen));
        if (mPendWen) begin
            check("m_rf_waddr", 64'(rf_waddr), 64'(mPendAddr));
            check("m_rf_wdata", 64'(rf_wdata), 64'(unsigned'(mPendData)));
        end
        check("m_busy_vec", 64'(busy_vec), 64'(vec));
        check("m_pend_cnt", 64'(pend_cnt), 64'(cnt));
        check("m_err_spur", 64'(err_spur), 64'(mErr));
        if (rf_wen) wrCnt[int'(rf_waddr)]++;
    endtask

    // One cycle: compare mid-cycle, then step to just after the next edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) cmpModel();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        exu_valid = 1'b0;
        lsu_valid = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d);
        iss_valid = 1'b1;
        iss_rs1 = a;
        iss_rs2 = b;
        iss_rd  = d;
    endtask

    task automatic wbExu(input logic [AW-1:0] d, input logic [DW-1:0] v);
        exu_valid = 1'b1;
        exu_rd    = d;
        exu_data  = v;
    endtask

    task automatic wbLsu(input logic [AW-1:0] d, input logic [DW-1:0] v);
        lsu_valid = 1'b1;
        lsu_rd    = d;
        lsu_data  = v;
    endtask

    task automatic resetDut();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < int'(NR); i++) wrCnt[i] = 0;

        // Reset state and reset with a granted result still pending.
        resetDut();
        check("rst_busy", 64'(busy_vec), 64'h0);
        check("rst_pend", 64'(pend_cnt), 64'h0);
        check("rst_wen", 64'(rf_wen), 64'h0);
        check("rst_waddr", 64'(rf_waddr), 64'h0);
        check("rst_wdata", 64'(rf_wdata), 64'h0);
        check("rst_err", 64'(err_spur), 64'h0);
        issue(0, 0, 5);
        tick();
        idle();
        snap[5] = wrCnt[5];
        wbExu(5, 32'h1111);
        #1;
        check("t1_grant", 64'(exu_ready), 64'h1);
        tick();
        idle();
        check("t1_wen_pre", 64'(rf_wen), 64'h1);
        #2 rst = 1'b1;
        #1;
        check("t1_wen_rst", 64'(rf_wen), 64'h0);
        check("t1_busy_rst", 64'(busy_vec), 64'h0);
        check("t1_err_rst", 64'(err_spur), 64'h0);
        tick();
        rst = 1'b0;
        #1;
        tick();
        check("t1_no_write", 64'(wrCnt[5] - snap[5]), 64'h0);

        // RAW stall on x5, EXU writeback, stalled issue proceeds.
        resetDut();
        issue(0, 0, 5);
        #1;
        check("t2_ready0", 64'(iss_ready), 64'h1);
        tick();
        check("t2_busy5", 64'(busy_vec), 64'h20);
        check("t2_pend1", 64'(pend_cnt), 64'h1);
        issue(5, 0, 6);
        wbExu(5, 32'hA5);
        #1;
        check("t2_stall", 64'(iss_ready), 64'h0);
        check("t2_exu_g", 64'(exu_ready), 64'h1);
        tick();
        exu_valid = 1'b0;
        #1;
        check("t2_wen", 64'(rf_wen), 64'h1);
        check("t2_waddr", 64'(rf_waddr), 64'h5);
        check("t2_wdata", 64'(rf_wdata), 64'hA5);
        check("t2_stall2", 64'(iss_ready), 64'h0);
        tick();
        check("t2_busy_clr", 64'(busy_vec), 64'h0);
        check("t2_go", 64'(iss_ready), 64'h1);
        tick();
        idle();
        check("t2_busy6", 64'(busy_vec), 64'h40);

        // Contention from reset: EXU, LSU, EXU, LSU.
        resetDut();
        issue(0, 0, 3);
        tick();
        issue(0, 0, 4);
        tick();
        idle();
        snap[3] = wrCnt[3];
        snap[4] = wrCnt[4];
        wbExu(4, 32'h44);
        wbLsu(3, 32'h33);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_exu_g", 64'(exu_ready), 64'((k % 2) == 0));
            check("t3_lsu_g", 64'(lsu_ready), 64'((k % 2) == 1));
            tick();
        end
        idle();
        tick();
        tick();
        check("t3_wr_x4", 64'(wrCnt[4] - snap[4]), 64'h2);
        check("t3_wr_x3", 64'(wrCnt[3] - snap[3]), 64'h2);
        check("t3_err", 64'(err_spur), 64'h1);

        // x0 never stalls, never writes, never marks busy.
        resetDut();
        issue(0, 0, 9);
        tick();
        issue(0, 0, 0);
        wbExu(0, 32'hFFFF_FFFF);
        #1;
        check("t4_ready", 64'(iss_ready), 64'h1);
        check("t4_exu_g", 64'(exu_ready), 64'h1);
        tick();
        idle();
        #1;
        check("t4_wen", 64'(rf_wen), 64'h0);
        check("t4_busy", 64'(busy_vec), 64'h200);
        check("t4_pend", 64'(pend_cnt), 64'h1);
        check("t4_err", 64'(err_spur), 64'h0);
        tick();

        // Spurious writeback to non-busy x7 is performed and flagged.
        resetDut();
        wbLsu(7, 32'h77);
        tick();
        idle();
        check("t5_wen", 64'(rf_wen), 64'h1);
        check("t5_waddr", 64'(rf_waddr), 64'h7);
        check("t5_wdata", 64'(rf_wdata), 64'h77);
        check("t5_err", 64'(err_spur), 64'h1);
        issue(0, 0, 8);
        tick();
        idle();
        wbExu(8, 32'h88);
        tick();
        idle();
        tick();
        tick();
        check("t5_err_hold", 64'(err_spur), 64'h1);
        check("t5_busy", 64'(busy_vec), 64'h0);

        // Fill x1..x31, then drain alternately through EXU and LSU.
        resetDut();
        for (int i = 1; i < int'(NR); i++) begin
            issue(0, 0, AW'(i));
            tick();
        end
        idle();
        check("t6_pend_full", 64'(pend_cnt), 64'd31);
        check("t6_busy_full", 64'(busy_vec), 64'hFFFF_FFFE);
        for (int i = 0; i < int'(NR); i++) snap[i] = wrCnt[i];
        for (int i = 1; i < int'(NR); i++) begin
            idle();
            if (i % 2 == 1) wbExu(AW'(i), DW'(i * 32'h101));
            else            wbLsu(AW'(i), DW'(i * 32'h101));
            tick();
        end
        idle();
        tick();
        tick();
        check("t6_pend_empty", 64'(pend_cnt), 64'h0);
        check("t6_err", 64'(err_spur), 64'h0);
        begin
            int bad;
            bad = 0;
            for (int i = 1; i < int'(NR); i++) if (wrCnt[i] - snap[i] != 1) bad++;
            check("t6_write_once", 64'(bad), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
